rr_lock_arbiter: RTL

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_out_slice.sv | 44 ++++
 rtl/rr_lock_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default geometry for the round-robin lock arbiter.
// State encoding plus a modulo-N increment used for pointer wrap.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_N     = 4;
  localparam int ARB_ID_W  = 1;
  localparam int ARB_OFF_W = 3;
  localparam int ARB_BEATS = 1;

  // Explicit wrap so non-power-of-two channel counts never index past N-1.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/arb_out_slice.sv
// One-entry output register slice: accepts when empty or draining, one cycle of latency.
// Holds its payload stable while valid and the sink is not ready.
module arb_out_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter that can hold a grant for a BEATS-long locked burst.
// Define ARB_OUT_REG_EN to place a one-entry register slice on the output side.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int ID_W  = ARB_ID_W,
  parameter int OFF_W = ARB_OFF_W,
  parameter int BEATS = ARB_BEATS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          io_in_valid,
  output logic [N-1:0]          io_in_ready,
  input  logic [N*ID_W-1:0]     io_in_bits_id,
  input  logic [N*OFF_W-1:0]    io_in_bits_offset,
  input  logic                  io_out_ready,
  output logic                  io_out_valid,
  output logic [ID_W-1:0]       io_out_bits_id,
  output logic [OFF_W-1:0]      io_out_bits_offset,
  output logic [$clog2(N)-1:0]  io_chosen
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] lk_q, lk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PTR_W-1:0] grant;
  logic             found;
  int               idx;
  logic             core_vld;
  logic             core_rdy;
  logic             fire;
  logic [ID_W-1:0]  core_id;
  logic [OFF_W-1:0] core_off;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lk_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lk_q    <= lk_d;
      cnt_q   <= cnt_d;
    end
  end

  // With nothing valid in IDLE the grant rests on ptr, so io_chosen reports ptr.
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    idx   = int'(ptr_q);
    if (state_q == LOCKED) begin
      grant = lk_q;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && io_in_valid[idx]) begin
          found = 1'b1;
          grant = PTR_W'(idx);
        end
        idx = wrap_inc(idx, N);
      end
    end
  end

  assign core_vld = io_in_valid[grant];
  assign core_id  = io_in_bits_id[int'(grant)*ID_W +: ID_W];
  assign core_off = io_in_bits_offset[int'(grant)*OFF_W +: OFF_W];
  assign fire     = core_vld && core_rdy;

  always_comb begin
    io_in_ready        = '0;
    io_in_ready[grant] = core_rdy;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lk_d    = lk_q;
    cnt_d   = cnt_q;
    if (fire) begin
      if (state_q == IDLE) begin
        if (BEATS == 1) begin
          ptr_d = PTR_W'(wrap_inc(int'(grant), N));
        end else begin
          state_d = LOCKED;
          lk_d    = grant;
          cnt_d   = CNT_W'(1);
        end
      end else if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = PTR_W'(wrap_inc(int'(lk_q), N));
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef ARB_OUT_REG_EN
  localparam int DW = PTR_W + ID_W + OFF_W;
  logic [DW-1:0] slice_dat;

  arb_out_slice #(.W(DW)) u_out_slice (
    .clock     (clock),
    .reset     (reset),
    .in_vld_i  (core_vld),
    .in_rdy_o  (core_rdy),
    .in_dat_i  ({grant, core_id, core_off}),
    .out_vld_o (io_out_valid),
    .out_rdy_i (io_out_ready),
    .out_dat_o (slice_dat)
  );

  assign {io_chosen, io_out_bits_id, io_out_bits_offset} = slice_dat;
`else
  assign core_rdy           = io_out_ready;
  assign io_out_valid       = core_vld;
  assign io_out_bits_id     = core_id;
  assign io_out_bits_offset = core_off;
  assign io_chosen          = grant;
`endif

endmodule
